// File: rtl/adxl362_pkg.sv
// ============================================================================
// Module   : adxl362_pkg
// Purpose  : ADXL362 register map, measurement-mode constant, poller states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package adxl362_pkg;

  localparam logic [7:0] POWER_CTL    = 8'h2D;
  localparam logic [7:0] XDATA        = 8'h08;
  localparam logic [7:0] YDATA        = 8'h09;
  localparam logic [7:0] ZDATA        = 8'h0A;
  localparam logic [7:0] TEMP_L       = 8'h14;
  localparam logic [7:0] MEASURE_MODE = 8'h02;

  typedef enum logic [2:0] {
    INIT_ISSUE = 3'd0,
    INIT_WAIT  = 3'd1,
    IDLE       = 3'd2,
    RD_ISSUE   = 3'd3,
    RD_WAIT    = 3'd4,
    PUBLISH    = 3'd5
  } poll_state_t;

  // Register address for each step of the read sequence.
  function automatic logic [7:0] read_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return XDATA;
      2'd1:    return YDATA;
      2'd2:    return ZDATA;
      default: return TEMP_L;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/poll_timer.sv
// ============================================================================
// Module   : poll_timer
// Purpose  : Free-running 0..CLK_COUNT-1 counter that pulses tick on wrap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module poll_timer #(
  parameter int CLK_COUNT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_COUNT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/adxl362_poller.sv
// ============================================================================
// Module   : adxl362_poller
// Purpose  : Puts the ADXL362 in measurement mode, then periodically reads
//            X/Y/Z (and TEMP_L when POLL_TEMP_EN is defined) via an SPI
//            controller and publishes each set atomically.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adxl362_poller
  import adxl362_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int POLL_RATE     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ctrl_busy,
  input  logic       ctrl_done,
  input  logic [7:0] ctrl_data_received,
  output logic       ctrl_start,
  output logic       ctrl_write,
  output logic [7:0] ctrl_address,
  output logic [7:0] ctrl_data_to_send,
  output logic [7:0] x_axis,
  output logic [7:0] y_axis,
  output logic [7:0] z_axis,
  output logic [7:0] temp,
  output logic       sample_valid,
  output logic       init_done,
  output logic       overrun
);

  localparam int POLL_CLKS = CLK_FREQUENCY / POLL_RATE;

`ifdef POLL_TEMP_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  poll_state_t state, state_next;
  logic [1:0]  idx;
  logic        tick;
  logic        issue;
  logic        capture;
  logic        publish;
  logic [7:0]  sh_x, sh_y, sh_z;
  logic [7:0]  w_x, w_y, w_z;

  poll_timer #(
    .CLK_COUNT (POLL_CLKS)
  ) u_poll_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (init_done),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    publish    = 1'b0;
    case (state)
      INIT_ISSUE: if (!ctrl_busy) begin
        issue      = 1'b1;
        state_next = INIT_WAIT;
      end
      INIT_WAIT:  if (ctrl_done) state_next = IDLE;
      IDLE:       if (tick && enable) state_next = RD_ISSUE;
      RD_ISSUE:   if (!ctrl_busy) begin
        issue      = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT:    if (ctrl_done) begin
        capture = 1'b1;
        if (idx == LAST_IDX) begin
          publish    = 1'b1;
          state_next = PUBLISH;
        end else begin
          state_next = RD_ISSUE;
        end
      end
      PUBLISH:    state_next = IDLE;
      default:    state_next = INIT_ISSUE;
    endcase
  end

  // The final byte bypasses its shadow so sample_valid lands one cycle after
  // the last ctrl_done, with every output loaded on the same edge.
  assign w_x = (capture && idx == 2'd0) ? ctrl_data_received : sh_x;
  assign w_y = (capture && idx == 2'd1) ? ctrl_data_received : sh_y;
  assign w_z = (capture && idx == 2'd2) ? ctrl_data_received : sh_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INIT_ISSUE;
      idx               <= 2'd0;
      ctrl_start        <= 1'b0;
      ctrl_write        <= 1'b0;
      ctrl_address      <= 8'h00;
      ctrl_data_to_send <= 8'h00;
      sh_x              <= 8'h00;
      sh_y              <= 8'h00;
      sh_z              <= 8'h00;
      x_axis            <= 8'h00;
      y_axis            <= 8'h00;
      z_axis            <= 8'h00;
      sample_valid      <= 1'b0;
      init_done         <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      state        <= state_next;
      ctrl_start   <= issue;
      sample_valid <= publish;
      sh_x         <= w_x;
      sh_y         <= w_y;
      sh_z         <= w_z;

      if (issue) begin
        if (state == INIT_ISSUE) begin
          ctrl_write        <= 1'b1;
          ctrl_address      <= POWER_CTL;
          ctrl_data_to_send <= MEASURE_MODE;
        end else begin
          ctrl_write        <= 1'b0;
          ctrl_address      <= read_addr(idx);
          ctrl_data_to_send <= 8'h00;
        end
      end

      if (state == INIT_WAIT && ctrl_done) init_done <= 1'b1;

      if (state == IDLE && tick && enable) begin
        idx <= 2'd0;
      end else if (capture && idx != LAST_IDX) begin
        idx <= idx + 2'd1;
      end

      if (publish) begin
        x_axis <= w_x;
        y_axis <= w_y;
        z_axis <= w_z;
      end

      // Timer only runs after init, so any non-IDLE tick is a missed poll.
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

`ifdef POLL_TEMP_EN
  logic [7:0] sh_t, w_t;

  assign w_t = (capture && idx == 2'd3) ? ctrl_data_received : sh_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_t <= 8'h00;
      temp <= 8'h00;
    end else begin
      sh_t <= w_t;
      if (publish) temp <= w_t;
    end
  end
`else
  assign temp = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adxl362_poller.sv
// ============================================================================
// Module   : tb_adxl362_poller
// Purpose  : Directed, table-driven bench with a busy/done SPI controller model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adxl362_poller;

`ifdef POLL_TEMP_EN
  localparam int NREADS  = 4;
  localparam bit TEMP_ON = 1'b1;
`else
  localparam int NREADS  = 3;
  localparam bit TEMP_ON = 1'b0;
`endif

  localparam int W_START   = 0;
  localparam int W_DONE    = 1;
  localparam int W_VALID   = 2;
  localparam int W_INIT    = 3;
  localparam int W_START09 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       ctrl_busy = 1'b0;
  logic       ctrl_done = 1'b0;
  logic [7:0] ctrl_data_received = 8'h00;
  logic       ctrl_start, ctrl_write;
  logic [7:0] ctrl_address, ctrl_data_to_send;
  logic [7:0] x_axis, y_axis, z_axis, temp;
  logic       sample_valid, init_done, overrun;

  adxl362_poller #(
    .CLK_FREQUENCY (1000),
    .POLL_RATE     (10)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .ctrl_busy          (ctrl_busy),
    .ctrl_done          (ctrl_done),
    .ctrl_data_received (ctrl_data_received),
    .ctrl_start         (ctrl_start),
    .ctrl_write         (ctrl_write),
    .ctrl_address       (ctrl_address),
    .ctrl_data_to_send  (ctrl_data_to_send),
    .x_axis             (x_axis),
    .y_axis             (y_axis),
    .z_axis             (z_axis),
    .temp               (temp),
    .sample_valid       (sample_valid),
    .init_done          (init_done),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  // Controller model: busy from start until done, done model_delay cycles later.
  int         model_delay = 20;
  int         m_cnt = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] rx = 8'h00, ry = 8'h00, rz = 8'h00, rt = 8'h00;

  function automatic logic [7:0] resp(input logic [7:0] a);
    case (a)
      8'h08:   return rx;
      8'h09:   return ry;
      8'h0A:   return rz;
      8'h14:   return rt;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    ctrl_done <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        ctrl_busy          <= 1'b0;
        ctrl_done          <= 1'b1;
        ctrl_data_received <= resp(m_addr);
      end
    end else if (ctrl_start && !ctrl_busy) begin
      ctrl_busy <= 1'b1;
      m_cnt     <= model_delay;
      m_addr    <= ctrl_address;
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t log_q[$];
  int   bad_wdata = 0;

  always @(posedge clk) begin
    txn_t t;
    if (ctrl_start) begin
      t.wr   = ctrl_write;
      t.addr = ctrl_address;
      t.data = ctrl_data_to_send;
      log_q.push_back(t);
    end
    if (!ctrl_write && ctrl_data_to_send != 8'h00) bad_wdata++;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit prev_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int which, input int budget, input string what);
    bit hit;
    hit       = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        W_START:   hit = ctrl_start;
        W_DONE:    hit = ctrl_done;
        W_VALID:   hit = sample_valid;
        W_INIT:    hit = init_done;
        W_START09: hit = ctrl_start && ctrl_address == 8'h09;
        default:   hit = 1'b1;
      endcase
      if (!hit) prev_done = ctrl_done;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait %s: not seen within %0d cycles", what, budget);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({ctrl_start, ctrl_write, ctrl_address, ctrl_data_to_send,
                x_axis, y_axis, z_axis, temp, sample_valid, init_done, overrun});
  endfunction

  typedef struct {
    logic [7:0] rx, ry, rz, rt;
    logic [7:0] ex, ey, ez, et;
  } vec_t;

  vec_t       vecs[3];
  logic [7:0] exp_addr[4];
  logic [31:0] snap;
  int          sv_seen;

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h7F, 8'h11, 8'h22, 8'h33, TEMP_ON ? 8'h7F : 8'h00};
    vecs[1] = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h80, TEMP_ON ? 8'h01 : 8'h00};
    vecs[2] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'hC3, TEMP_ON ? 8'h3C : 8'h00};
    exp_addr[0] = 8'h08;
    exp_addr[1] = 8'h09;
    exp_addr[2] = 8'h0A;
    exp_addr[3] = 8'h14;

    // Reset and measurement-mode init
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", all_outputs(), 64'h0);
    rst = 1'b0;
    wait_for(W_START, 20, "init start");
    check("init write", 64'(ctrl_write), 64'h1);
    check("init addr", 64'(ctrl_address), 64'h2D);
    check("init data", 64'(ctrl_data_to_send), 64'h02);
    wait_for(W_DONE, 60, "init done pulse");
    check("init_done during done", 64'(init_done), 64'h0);
    @(negedge clk);
    check("init_done after done", 64'(init_done), 64'h1);
    log_q.delete();

    // Table-driven sample sets
    for (int i = 0; i < 3; i++) begin
      rx = vecs[i].rx; ry = vecs[i].ry; rz = vecs[i].rz; rt = vecs[i].rt;
      wait_for(W_VALID, 300, "sample_valid");
      check("valid latency", 64'(prev_done), 64'h1);
      check("x_axis", 64'(x_axis), 64'(vecs[i].ex));
      check("y_axis", 64'(y_axis), 64'(vecs[i].ey));
      check("z_axis", 64'(z_axis), 64'(vecs[i].ez));
      check("temp", 64'(temp), 64'(vecs[i].et));
      check("read count", 64'(log_q.size()), 64'(NREADS));
      for (int j = 0; j < NREADS && j < log_q.size(); j++) begin
        check("read addr", 64'(log_q[j].addr), 64'(exp_addr[j]));
        check("read dir", 64'(log_q[j].wr), 64'h0);
      end
      log_q.delete();
      check("overrun idle", 64'(overrun), 64'h0);
      @(negedge clk);
      check("sample_valid width", 64'(sample_valid), 64'h0);
    end

    // enable low: ticks ignored, outputs hold
    enable  = 1'b0;
    snap    = {x_axis, y_axis, z_axis, temp};
    sv_seen = 0;
    log_q.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sample_valid) sv_seen++;
    end
    check("disabled starts", 64'(log_q.size()), 64'h0);
    check("disabled valids", 64'(sv_seen), 64'h0);
    check("disabled outputs", 64'({x_axis, y_axis, z_axis, temp}), 64'(snap));
    check("disabled overrun", 64'(overrun), 64'h0);
    enable = 1'b1;

    // Slow controller: second tick lands mid-sequence
    rx = 8'h44; ry = 8'h55; rz = 8'h66; rt = 8'h77;
    model_delay = 50;
    wait_for(W_VALID, 600, "slow sample_valid");
    check("overrun set", 64'(overrun), 64'h1);
    check("slow x", 64'(x_axis), 64'h44);
    check("slow y", 64'(y_axis), 64'h55);
    check("slow z", 64'(z_axis), 64'h66);
    check("slow temp", 64'(temp), TEMP_ON ? 64'h77 : 64'h00);

    // Reset during the second read
    model_delay = 20;
    wait_for(W_START09, 400, "second read start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-read reset outputs", all_outputs(), 64'h0);
    rst = 1'b0;
    wait_for(W_START, 100, "re-init start");
    check("re-init write", 64'(ctrl_write), 64'h1);
    check("re-init addr", 64'(ctrl_address), 64'h2D);
    check("re-init data", 64'(ctrl_data_to_send), 64'h02);
    wait_for(W_INIT, 100, "re-init done");
    check("re-init init_done", 64'(init_done), 64'h1);

    check("read data zero", 64'(bad_wdata), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adxl362_poller.md
ADXL362_POLLER -- requirements
Module: adxl362_poller

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter POLL_RATE, default 2, meaning complete X/Y/Z sample sets per second.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 Ports: clk  in  1  system clock.
REQ-005 Ports: rst  in  1  synchronous active-high reset.
REQ-006 Ports: enable  in  1  allows periodic polling when high.
REQ-007 Ports: ctrl_busy  in  1  SPI controller busy.
REQ-008 Ports: ctrl_done  in  1  one-cycle pulse marking the end of a controller transaction.
REQ-009 Ports: ctrl_data_received  in  8  read byte from the controller.
REQ-010 Ports: ctrl_start / ctrl_write  out  1 / 1  transaction request and direction (1 = write).
REQ-011 Ports: ctrl_address / ctrl_data_to_send  out  8 / 8  register address and write byte.
REQ-012 Ports: x_axis, y_axis, z_axis, temp  out  8 each  latest sample bytes.
REQ-013 Ports: sample_valid  out  1  one-cycle pulse when a new sample set is published.
REQ-014 Ports: init_done  out 1  measurement mode configured; overrun  out 1  sticky missed-tick flag.

Function
REQ-015 States: INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH.
REQ-016 INIT_ISSUE:
- Entered after reset.
- Waits until ctrl_busy = 0.
- Drives ctrl_start = 1 for exactly one cycle with ctrl_write = 1, ctrl_address = 0x2D, ctrl_data_to_send = 0x02.
- Then moves to INIT_WAIT.
REQ-017 INIT_WAIT: on ctrl_done, set init_done = 1 and go to IDLE.
REQ-018 Poll tick:
- Counter runs 0..POLL_CLKS-1 and wraps; POLL_CLKS = CLK_FREQUENCY/POLL_RATE.
- tick = 1 for one cycle on the wrap.
- Counter runs only when init_done = 1.
REQ-019 IDLE: when tick = 1 and enable = 1, load read index 0 and go to RD_ISSUE; when enable = 0, ignore tick.
REQ-020 Read sequence: 0x08 -> 0x09 -> 0x0A (-> 0x14 with POLL_TEMP_EN).
REQ-021 RD_ISSUE:
- Waits until ctrl_busy = 0.
- Pulses ctrl_start for one cycle with ctrl_write = 0 and ctrl_address = the current sequence address.
- Then moves to RD_WAIT.
REQ-022 RD_WAIT:
- On ctrl_done, capture ctrl_data_received into a shadow register.
- If more addresses remain, advance the index and go to RD_ISSUE; otherwise go to PUBLISH.
REQ-023 PUBLISH:
- Copy all shadow registers to the outputs simultaneously.
- Pulse sample_valid for one cycle.
- Return to IDLE.
- Outputs never show a partially updated set.
REQ-024 Latency: sample_valid asserts exactly 1 cycle after the ctrl_done of the final read.
REQ-025 A tick arriving in any state other than IDLE (with init_done = 1) sets overrun = 1 until reset; that tick is dropped, not queued.
REQ-026 enable falling mid-sequence does not abort the sequence; it completes and publishes.
REQ-027 A ctrl_done arriving in IDLE or an ISSUE state is ignored.
REQ-028 ctrl_data_to_send = 0x00 whenever ctrl_write = 0.

Reset
REQ-029 rst SHALL, on the next clock edge:
- Return the state to INIT_ISSUE.
- Clear the tick counter and read index.
- Set all outputs to 0: ctrl_start, ctrl_write, ctrl_address, ctrl_data_to_send, x_axis, y_axis, z_axis, temp, sample_valid, init_done, overrun.
- Clear the shadow registers.
REQ-030 Reset mid-transaction SHALL drop the transaction; reinitialisation reissues the POWER_CTL write.

Configuration
REQ-031 With macro POLL_TEMP_EN defined:
- The sequence is 4 reads, appending 0x14 (TEMP_L).
- temp is updated in PUBLISH.
REQ-032 Without POLL_TEMP_EN:
- The sequence is 3 reads.
- temp is held at 0x00.
- No temperature shadow register exists.

Structure
REQ-033 Package adxl362_pkg SHALL hold:
- Register address constants: POWER_CTL = 0x2D, XDATA = 0x08, YDATA = 0x09, ZDATA = 0x0A, TEMP_L = 0x14.
- Constant MEASURE_MODE = 0x02.
- The poller state enum typedef.
REQ-034 The tick generator SHALL be sub-module poll_timer:
- Parameter: CLK_COUNT.
- Ports: clk, rst, run, tick.

Verification (CLK_FREQUENCY = 1000, POLL_RATE = 10, so POLL_CLKS = 100; controller model asserts busy and pulses done 20 cycles after start)
REQ-035 Reset release:
- Expect one start with write = 1, addr 0x2D, data 0x02.
- Expect init_done = 1 the cycle after done.
REQ-036 Model returns 0x11/0x22/0x33 for 0x08/0x09/0x0A:
- Expect reads in that address order.
- Expect a sample_valid pulse, then x = 0x11, y = 0x22, z = 0x33.
REQ-037 Hold enable = 0 for 300 cycles: expect no ctrl_start and outputs unchanged.
REQ-038 Model done delay of 50 cycles: expect overrun = 1 after the second tick lands mid-sequence, and the sequence still publishes.
REQ-039 Assert rst during the second read:
- Expect all outputs = 0 next cycle.
- Expect a fresh POWER_CTL write.
REQ-040 With POLL_TEMP_EN and the model returning 0x7F at 0x14: expect 4 reads and temp = 0x7F at sample_valid.
